// File: rtl/fr_cnn_pkg.sv
// Shared widths, sizes and FSM encoding for the 1-D convolution layer.
// Everything is Q8.8 fixed point.
package fr_cnn_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int N_IN   = 32;
  localparam int K      = 3;
  localparam int N_OUT  = 30;
  localparam int ACC_W  = 34;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/fr_mac_unit.sv
// Single-multiplier accumulator with bias, Q8.8 rescale, saturation and ReLU.
// The result on y_o is combinational from the accumulator.
module fr_mac_unit import fr_cnn_pkg::*; #(
  parameter logic signed [DATA_W-1:0] BIAS = 16'sh0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] w_i,
  output logic signed [DATA_W-1:0] y_o
);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2**(DATA_W-1));
  // Bias is Q8.8; shifting it up by FRAC_W aligns it with the Q16.16 products.
  localparam logic signed [ACC_W-1:0] BIAS_EXT =
    {{(ACC_W-DATA_W-FRAC_W){BIAS[DATA_W-1]}}, BIAS, {FRAC_W{1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  biased;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat;

  assign prod     = x_i * w_i;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign biased  = acc_q + BIAS_EXT;
  assign shifted = biased >>> FRAC_W;

  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX) begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  assign y_o = sat[DATA_W-1] ? '0 : sat;
endmodule

// File: rtl/fr_conv1d_layer.sv
// 3-tap valid 1-D convolution over a captured 32-sample frame, one output
// every 4 cycles (3 MAC cycles plus one output cycle), 30 outputs per frame.
module fr_conv1d_layer import fr_cnn_pkg::*; #(
  parameter logic signed [DATA_W-1:0] W0   = 16'sh0100,
  parameter logic signed [DATA_W-1:0] W1   = 16'sh0100,
  parameter logic signed [DATA_W-1:0] W2   = 16'sh0100,
  parameter logic signed [DATA_W-1:0] BIAS = 16'sh0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_ready,
  input  logic signed [DATA_W-1:0] x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
  input  logic signed [DATA_W-1:0] x8,  x9,  x10, x11, x12, x13, x14, x15,
  input  logic signed [DATA_W-1:0] x16, x17, x18, x19, x20, x21, x22, x23,
  input  logic signed [DATA_W-1:0] x24, x25, x26, x27, x28, x29, x30, x31,
  output logic signed [DATA_W-1:0] y_data,
  output logic                     y_valid,
  output logic [4:0]               y_index,
  output logic                     done
);
  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_in [N_IN];
  logic signed [DATA_W-1:0] x_q  [N_IN];
  logic [4:0]               n_q, n_d;
  logic [1:0]               k_q, k_d;
  logic [4:0]               tap_idx;
  logic signed [DATA_W-1:0] w_sel;
  logic signed [DATA_W-1:0] mac_y;
  logic                     capture, mac_clr, mac_en, out_fire, flush;

  logic signed [DATA_W-1:0] y_data_q;
  logic                     y_valid_q;
  logic [4:0]               y_index_q;
  logic                     done_q;

  assign x_in = '{x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
                  x8,  x9,  x10, x11, x12, x13, x14, x15,
                  x16, x17, x18, x19, x20, x21, x22, x23,
                  x24, x25, x26, x27, x28, x29, x30, x31};

  // start low acts as a soft clear of the whole block.
  assign flush = rst || !start;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    capture  = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    out_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_ready) begin
          capture = 1'b1;
          mac_clr = 1'b1;
          n_d     = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == 2'(K - 1)) begin
          k_d     = '0;
          state_d = OUT;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      OUT: begin
        out_fire = 1'b1;
        mac_clr  = 1'b1;
        if (n_q == 5'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + 5'd1;
          state_d = MAC;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      n_d      = '0;
      k_d      = '0;
      capture  = 1'b0;
      mac_clr  = 1'b1;
      mac_en   = 1'b0;
      out_fire = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (flush) begin
        x_q[i] <= '0;
      end else if (capture) begin
        x_q[i] <= x_in[i];
      end
    end
  end

  // n never exceeds N_OUT-1 and k never exceeds K-1, so the tap index stays in 0..31.
  assign tap_idx = n_q + 5'(k_q);

  always_comb begin
    case (k_q)
      2'd0:    w_sel = W0;
      2'd1:    w_sel = W1;
      default: w_sel = W2;
    endcase
  end

  fr_mac_unit #(
    .BIAS(BIAS)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .x_i  (x_q[tap_idx]),
    .w_i  (w_sel),
    .y_o  (mac_y)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_index_q <= '0;
      done_q    <= 1'b0;
    end else begin
      y_valid_q <= out_fire;
      if (out_fire) begin
        y_data_q  <= mac_y;
        y_index_q <= n_q;
        if (n_q == 5'(N_OUT - 1)) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign y_index = y_index_q;
  assign done    = done_q;
endmodule

// File: tb/tb_fr_conv1d_layer.sv
// Scoreboard bench: two layer instances (default taps and asymmetric taps with
// bias) share one stimulus; monitors pop expected outputs on every y_valid.
module tb_fr_conv1d_layer;
  localparam logic signed [15:0] WB0 = 16'sh0100;
  localparam logic signed [15:0] WB1 = 16'shFF80;
  localparam logic signed [15:0] WB2 = 16'sh0200;
  localparam logic signed [15:0] BB  = 16'sh0080;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, in_ready;
  logic signed [15:0] xin [32];
  int xv [32];

  logic signed [15:0] y_data_a, y_data_b;
  logic               y_valid_a, y_valid_b;
  logic [4:0]         y_index_a, y_index_b;
  logic               done_a, done_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fr_conv1d_layer dut_a (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .x0(xin[0]),   .x1(xin[1]),   .x2(xin[2]),   .x3(xin[3]),
    .x4(xin[4]),   .x5(xin[5]),   .x6(xin[6]),   .x7(xin[7]),
    .x8(xin[8]),   .x9(xin[9]),   .x10(xin[10]), .x11(xin[11]),
    .x12(xin[12]), .x13(xin[13]), .x14(xin[14]), .x15(xin[15]),
    .x16(xin[16]), .x17(xin[17]), .x18(xin[18]), .x19(xin[19]),
    .x20(xin[20]), .x21(xin[21]), .x22(xin[22]), .x23(xin[23]),
    .x24(xin[24]), .x25(xin[25]), .x26(xin[26]), .x27(xin[27]),
    .x28(xin[28]), .x29(xin[29]), .x30(xin[30]), .x31(xin[31]),
    .y_data(y_data_a), .y_valid(y_valid_a), .y_index(y_index_a), .done(done_a)
  );

  fr_conv1d_layer #(
    .W0(WB0), .W1(WB1), .W2(WB2), .BIAS(BB)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .x0(xin[0]),   .x1(xin[1]),   .x2(xin[2]),   .x3(xin[3]),
    .x4(xin[4]),   .x5(xin[5]),   .x6(xin[6]),   .x7(xin[7]),
    .x8(xin[8]),   .x9(xin[9]),   .x10(xin[10]), .x11(xin[11]),
    .x12(xin[12]), .x13(xin[13]), .x14(xin[14]), .x15(xin[15]),
    .x16(xin[16]), .x17(xin[17]), .x18(xin[18]), .x19(xin[19]),
    .x20(xin[20]), .x21(xin[21]), .x22(xin[22]), .x23(xin[23]),
    .x24(xin[24]), .x25(xin[25]), .x26(xin[26]), .x27(xin[27]),
    .x28(xin[28]), .x29(xin[29]), .x30(xin[30]), .x31(xin[31]),
    .y_data(y_data_b), .y_valid(y_valid_b), .y_index(y_index_b), .done(done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // y[n] = ReLU(sat16((sum x[n+k]*Wk + BIAS*256) >>> 8))
  function automatic logic [15:0] ref_y(input int n, input int w0, input int w1,
                                        input int w2, input int b);
    longint acc, s;
    acc = longint'(xv[n]) * w0 + longint'(xv[n+1]) * w1 + longint'(xv[n+2]) * w2
        + longint'(b) * 256;
    s = acc >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (s < 0) s = 0;
    return s[15:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (y_valid_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got pulse idx %0d data %h, required no pulse", y_index_a, y_data_a);
      end else begin
        e = q_a.pop_front();
        $display("a y[%0d] = %h (exp %h)", y_index_a, y_data_a, e.data);
        chk("a_index", 32'(y_index_a), 32'(e.idx));
        chk("a_data", 32'(y_data_a), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (y_valid_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got pulse idx %0d data %h, required no pulse", y_index_b, y_data_b);
      end else begin
        e = q_b.pop_front();
        $display("b y[%0d] = %h (exp %h)", y_index_b, y_data_b, e.data);
        chk("b_index", 32'(y_index_b), 32'(e.idx));
        chk("b_data", 32'(y_data_b), 32'(e.data));
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_a_y_data"},  32'(y_data_a),  0);
    chk({tag, "_a_y_valid"}, 32'(y_valid_a), 0);
    chk({tag, "_a_y_index"}, 32'(y_index_a), 0);
    chk({tag, "_a_done"},    32'(done_a),    0);
    chk({tag, "_b_y_data"},  32'(y_data_b),  0);
    chk({tag, "_b_y_valid"}, 32'(y_valid_b), 0);
    chk({tag, "_b_y_index"}, 32'(y_index_b), 0);
    chk({tag, "_b_done"},    32'(done_b),    0);
  endtask

  task automatic load_pattern(input int pat);
    for (int i = 0; i < 32; i++) begin
      case (pat)
        0:       xv[i] = 256;
        1:       xv[i] = i * 256;
        2:       xv[i] = -256;
        3:       xv[i] = 32767;
        default: xv[i] = (i % 2 == 0) ? 1024 : -512;
      endcase
      xin[i] = 16'(xv[i]);
    end
  endtask

  // abort: 0 = full frame, 1 = drop start after pulse n_exp-1, 2 = rst after pulse n_exp-1
  task automatic run_frame(input int pat, input int n_exp, input int abort);
    int c;
    load_pattern(pat);
    for (int n = 0; n < n_exp; n++) begin
      q_a.push_back('{idx: n, data: ref_y(n, 256, 256, 256, 0)});
      q_b.push_back('{idx: n, data: ref_y(n, int'(WB0), int'(WB1), int'(WB2), int'(BB))});
    end
    rst = 1'b0;
    start = 1'b1;
    in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    for (int i = 0; i < 32; i++) xin[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("latency_early_valid", 32'(y_valid_a), 0);
    @(posedge clk); #1;
    chk("latency_first_valid", 32'(y_valid_a), 1);
    if (abort == 0) begin
      c = 0;
      while (!done_a && c < 200) begin
        @(posedge clk); #1;
        c++;
      end
      chk("a_done_set", 32'(done_a), 1);
      chk("b_done_set", 32'(done_b), 1);
      @(negedge clk); #1;
      chk("a_queue_drained", 32'(q_a.size()), 0);
      chk("b_queue_drained", 32'(q_b.size()), 0);
      in_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("a_done_sticky", 32'(done_a), 1);
      chk("b_done_sticky", 32'(done_b), 1);
      in_ready = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      chk_idle("after_done");
    end else begin
      c = 0;
      while (!(y_valid_a && y_index_a == 5'(n_exp - 1)) && c < 200) begin
        @(posedge clk); #1;
        c++;
      end
      chk("abort_point_seen", 32'(y_valid_a && y_index_a == 5'(n_exp - 1)), 1);
      if (abort == 1) start = 1'b0;
      else rst = 1'b1;
      @(posedge clk); #1;
      chk_idle(abort == 1 ? "start_drop" : "mid_rst");
      repeat (12) @(posedge clk);
      #1;
      chk("a_abort_drained", 32'(q_a.size()), 0);
      chk("b_abort_drained", 32'(q_b.size()), 0);
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      xin[i] = '0;
      xv[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_idle("idle_no_ready");
    start = 1'b0;
    @(posedge clk); #1;

    run_frame(0, 30, 0);   // all 1.0: y = 3.0 on both instances
    run_frame(1, 30, 0);   // ramp
    run_frame(4, 11, 1);   // alternating, start dropped after y[10]
    run_frame(4, 30, 0);   // full restart from y[0]
    run_frame(1, 5, 2);    // rst during MAC of n=5
    run_frame(1, 30, 0);   // fresh capture after rst release
    run_frame(2, 30, 0);   // negative inputs: ReLU
    run_frame(3, 30, 0);   // max inputs: saturation

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fr_conv1d_layer.md
FR_CONV1D_LAYER -- requirements
Module: fr_conv1d_layer

Interface
REQ-001 SHALL have parameter W0, default 16'sh0100, kernel tap 0 (signed Q8.8).
REQ-002 SHALL have parameter W1, default 16'sh0100, kernel tap 1 (signed Q8.8).
REQ-003 SHALL have parameter W2, default 16'sh0100, kernel tap 2 (signed Q8.8).
REQ-004 SHALL have parameter BIAS, default 16'sh0000, output bias (signed Q8.8).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  session enable; low holds block cleared and idle.
REQ-008 SHALL have port in_ready  input  1  upstream frame valid; held high while x0..x31 stable.
REQ-009 SHALL have ports x0..x31  input  16 each, signed  frame samples, Q8.8, x0 oldest.
REQ-010 SHALL have port y_data  output  16 signed  convolution result, Q8.8, post-ReLU.
REQ-011 SHALL have port y_valid  output  1  y_data/y_index valid, one-cycle pulse.
REQ-012 SHALL have port y_index  output  5  output position n, 0..29.
REQ-013 SHALL have port done  output  1  all 30 outputs produced; sticky until start low or rst.

Function
REQ-014 SHALL compute y[n] = ReLU(sat16((sum k=0..2 of x[n+k]*Wk + (BIAS<<<8)) >>> 8)), n=0..29 (valid convolution, 30 outputs).
REQ-015 SHALL form products at 32 bits and accumulate at 34 bits signed; no intermediate overflow.
REQ-016 SHALL use arithmetic right shift by 8 (truncation toward minus infinity), then saturate to [-32768, 32767], then clamp negatives to 0.
REQ-017 SHALL use FSM states IDLE, MAC, OUT, DONE.
REQ-018 IDLE: on an edge sampling in_ready=1, SHALL capture x0..x31 into internal registers, clear accumulator, n=0, k=0, go to MAC.
REQ-019 MAC: SHALL add x[n+k]*Wk per cycle for k=0,1,2 (one multiplier, 3 cycles), then go to OUT.
REQ-020 OUT: SHALL register y_data, y_index=n, y_valid=1 for exactly one cycle, clear accumulator; if n<29 increment n and return to MAC, else go to DONE.
REQ-021 First y_valid SHALL be visible in the cycle after the 4th rising edge following the capture edge; subsequent pulses every 4 cycles; 30 pulses total, y_index 0..29 ascending.
REQ-022 DONE: SHALL hold done=1, y_valid=0, ignore in_ready; only start low or rst leaves DONE.
REQ-023 Captured samples SHALL be used; changes on x0..x31 or in_ready after capture SHALL not affect results.
REQ-024 start low in any state, including mid-MAC, SHALL on the next edge force IDLE and all outputs and internal registers to 0; no further y_valid until a new capture.
REQ-025 in_ready low in IDLE SHALL leave the block idle with outputs 0.
REQ-026 y_data SHALL hold its last value between y_valid pulses.

Reset
REQ-027 rst SHALL take priority over start and force on the next edge: state IDLE, y_data=0, y_valid=0, y_index=0, done=0, accumulator, n, k and sample registers 0.
REQ-028 rst asserted mid-frame SHALL abort the frame; no partial outputs after release.

Structure
REQ-029 Constants DATA_W=16, FRAC_W=8, N_IN=32, K=3, N_OUT=30, ACC_W=34 and state encodings SHALL live in shared package fr_cnn_pkg.
REQ-030 The multiply, accumulate, shift, saturate and ReLU datapath SHALL be sub-module fr_mac_unit; the FSM, counters and sample registers stay in the top.

Verification
REQ-031 All x=16'sh0100, defaults, start=1, in_ready pulse held -> 30 pulses, y_data=16'sh0300, y_index 0..29, then done=1.
REQ-032 x[i]=i*16'sh0100, W0=16'sh0100, W1=W2=0 -> y[n]=n*16'sh0100.
REQ-033 All x=16'sh0100, W0=W1=W2=16'shFF00 -> every y_data=0 (ReLU).
REQ-034 All x=16'sh7FFF, W0=W1=W2=16'sh7FFF -> every y_data=16'sh7FFF (saturation).
REQ-035 start dropped after y_index=10 pulse -> next edge all outputs 0, no further y_valid; start and in_ready re-asserted -> full 30-output run restarts from y_index 0.
REQ-036 rst asserted during MAC of n=5 with start=1 -> outputs 0, state IDLE; after release with in_ready high, new capture and full run.
